// File: rtl/spdif_pkg.sv
// Shared types and constants for the S/PDIF transmit scheduler.
package spdif_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_RUN,
    S_UNDERRUN
  } sched_state_e;

  localparam int BLOCK_FRAMES_DEF = 192;

  typedef struct packed {
    logic [31:0] left;
    logic [31:0] right;
  } pair_t;

  localparam pair_t MUTE_PAIR    = '0;
  localparam logic  V_INVALID    = 1'b1;
  localparam logic  V_VALID      = 1'b0;

endpackage

// File: rtl/spdif_sched_fifo.sv
// Synchronous FIFO of stereo pairs with occupancy count and single-cycle flush.
module spdif_sched_fifo
  import spdif_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  pair_t         wr_data,
  output pair_t         rd_data,
  output logic [CW-1:0] count
);

  pair_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  assign rd_data = mem[rd_ptr];

  // Storage carries no reset; only pointers and count define occupancy.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/spdif_tx_scheduler.sv
// Frame-strobed pair scheduler with priming, mute and underrun recovery.
// Optional SPDIF_TX_SCHED_STATS_EN adds a saturating underrun counter port.
module spdif_tx_scheduler
  import spdif_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int PRIME_LEVEL  = 2,
  parameter int BLOCK_FRAMES = BLOCK_FRAMES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_left,
  input  logic [31:0] in_right,
  input  logic [3:0]  rate_code_req,
  input  logic        frame_tick,
  output logic [31:0] data_left,
  output logic [31:0] data_right,
  output logic        validity,
  output logic [3:0]  sample_rate_code,
  output logic        block_start,
  output logic        underrun_flag
`ifdef SPDIF_TX_SCHED_STATS_EN
  ,
  output logic [15:0] underrun_count
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = $clog2(BLOCK_FRAMES);

  sched_state_e  state, state_n;
  logic [CW-1:0] count;
  logic [FW-1:0] fidx;
  pair_t         rd_pair;
  logic          push, pop, load, mute, set_uf, tick_act, en_q;

  assign in_ready = enable && (count != CW'(FIFO_DEPTH));
  assign push     = in_valid && in_ready;
  assign tick_act = enable && frame_tick && (state != S_IDLE);

  spdif_sched_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (!enable),
    .push    (push),
    .pop     (pop),
    .wr_data ('{left: in_left, right: in_right}),
    .rd_data (rd_pair),
    .count   (count)
  );

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    load    = 1'b0;
    mute    = 1'b0;
    set_uf  = 1'b0;
    if (!enable) begin
      state_n = S_IDLE;
      mute    = 1'b1;
    end else begin
      case (state)
        S_IDLE: state_n = S_PRIME;
        S_PRIME, S_UNDERRUN:
          if (frame_tick) begin
            if (count >= CW'(PRIME_LEVEL)) begin
              pop     = 1'b1;
              load    = 1'b1;
              state_n = S_RUN;
            end else begin
              mute = 1'b1;
            end
          end
        S_RUN:
          // Pre-push count decides: a pair arriving with the tick is too late.
          if (frame_tick) begin
            if (count != '0) begin
              pop  = 1'b1;
              load = 1'b1;
            end else begin
              mute    = 1'b1;
              set_uf  = 1'b1;
              state_n = S_UNDERRUN;
            end
          end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      en_q             <= 1'b0;
      data_left        <= '0;
      data_right       <= '0;
      validity         <= V_INVALID;
      sample_rate_code <= '0;
      block_start      <= 1'b0;
      underrun_flag    <= 1'b0;
      fidx             <= '0;
    end else begin
      state       <= state_n;
      en_q        <= enable;
      block_start <= 1'b0;
      if (load) begin
        data_left  <= rd_pair.left;
        data_right <= rd_pair.right;
        validity   <= V_VALID;
      end else if (mute) begin
        data_left  <= MUTE_PAIR.left;
        data_right <= MUTE_PAIR.right;
        validity   <= V_INVALID;
      end
      if (enable && !en_q)  underrun_flag <= 1'b0;
      else if (set_uf)      underrun_flag <= 1'b1;
      // Rate code is latched at session start and otherwise only at block wrap.
      if (enable && state == S_IDLE) begin
        fidx             <= '0;
        sample_rate_code <= rate_code_req;
      end else if (tick_act) begin
        if (fidx == FW'(BLOCK_FRAMES - 1)) begin
          fidx             <= '0;
          block_start      <= 1'b1;
          sample_rate_code <= rate_code_req;
        end else begin
          fidx <= fidx + FW'(1);
        end
      end
    end
  end

`ifdef SPDIF_TX_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)                                 underrun_count <= '0;
    else if (set_uf && underrun_count != '1) underrun_count <= underrun_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_spdif_tx_scheduler.sv
// Randomized bench for spdif_tx_scheduler against a queue-based frame model.
module tb_spdif_tx_scheduler;
  localparam int DEPTH = 4;
  localparam int PRIME = 2;
  localparam int BLOCK = 192;

  logic        clk = 1'b0;
  logic        rst, enable, in_valid, in_ready, frame_tick;
  logic [31:0] in_left, in_right, data_left, data_right;
  logic [3:0]  rate_code_req, sample_rate_code;
  logic        validity, block_start, underrun_flag;
`ifdef SPDIF_TX_SCHED_STATS_EN
  logic [15:0] underrun_count;
`endif

  always #5 clk = ~clk;

  spdif_tx_scheduler #(.FIFO_DEPTH(DEPTH), .PRIME_LEVEL(PRIME), .BLOCK_FRAMES(BLOCK)) dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_left          (in_left),
    .in_right         (in_right),
    .rate_code_req    (rate_code_req),
    .frame_tick       (frame_tick),
    .data_left        (data_left),
    .data_right       (data_right),
    .validity         (validity),
    .sample_rate_code (sample_rate_code),
    .block_start      (block_start),
    .underrun_flag    (underrun_flag)
`ifdef SPDIF_TX_SCHED_STATS_EN
    ,
    .underrun_count   (underrun_count)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // Model state: a session is "active" once enable has been seen high for a cycle.
  logic [63:0] q[$];
  bit          active, need_prime, en_prev, last_tk;
  int          fnum, ucount;
  logic [31:0] e_l, e_r;
  logic        e_val, e_blk, e_uf;
  logic [3:0]  e_rate;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit r, input bit en, input bit v, input bit tk,
                       input logic [63:0] pair, input logic [3:0] req);
    bit          pushed;
    int          pre;
    logic [63:0] p;
    if (r) begin
      q.delete(); active = 0; need_prime = 1; en_prev = 0; fnum = 0; ucount = 0;
      e_l = 0; e_r = 0; e_val = 1; e_blk = 0; e_uf = 0; e_rate = 0;
      return;
    end
    pushed = v && en && (q.size() < DEPTH);
    e_blk = 0;
    if (en && !en_prev) e_uf = 0;
    en_prev = en;
    if (!en) begin
      q.delete(); active = 0; e_l = 0; e_r = 0; e_val = 1;
    end else if (!active) begin
      active = 1; need_prime = 1; fnum = 0; e_rate = req;
      if (pushed) q.push_back(pair);
    end else begin
      pre = q.size();
      if (pushed) q.push_back(pair);
      if (tk) begin
        if (pre >= (need_prime ? PRIME : 1)) begin
          p = q.pop_front(); e_l = p[63:32]; e_r = p[31:0]; e_val = 0; need_prime = 0;
        end else begin
          e_l = 0; e_r = 0; e_val = 1;
          if (!need_prime) begin
            e_uf = 1;
            if (ucount < 65535) ucount++;
          end
          need_prime = 1;
        end
        fnum++;
        if (fnum == BLOCK) begin
          fnum = 0; e_blk = 1; e_rate = req;
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit en, input bit v, input bit tk_req);
    logic [63:0] pair;
    bit          tk;
    tk = tk_req && !last_tk;
    last_tk = tk;
    pair = {$urandom, $urandom};
    rst = r; enable = en; in_valid = v; frame_tick = tk;
    in_left = pair[63:32]; in_right = pair[31:0];
    @(posedge clk);
    model(r, en, v, tk, pair, rate_code_req);
    #1;
    chk("data_left", data_left, e_l);
    chk("data_right", data_right, e_r);
    chk("validity", {31'b0, validity}, {31'b0, e_val});
    chk("sample_rate_code", {28'b0, sample_rate_code}, {28'b0, e_rate});
    chk("block_start", {31'b0, block_start}, {31'b0, e_blk});
    chk("underrun_flag", {31'b0, underrun_flag}, {31'b0, e_uf});
    chk("in_ready", {31'b0, in_ready}, {31'b0, (en && q.size() < DEPTH)});
`ifdef SPDIF_TX_SCHED_STATS_EN
    chk("underrun_count", {16'b0, underrun_count}, ucount[31:0]);
`endif
  endtask

  task automatic tick(input bit v);
    step(0, 1, v, 1);
    step(0, 1, 0, 0);
  endtask

  initial begin
    rate_code_req = 4'h0;
    last_tk = 0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    // Prime with two pairs, play them, then underrun.
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    step(0, 1, 0, 0);
    tick(0); tick(0); tick(0);
    // Overfill: fifth push must be refused, order preserved.
    repeat (5) step(0, 1, 1, 0);
    repeat (5) tick(0);
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    tick(0); tick(0);
    // Rate change requested mid-block only lands at the wrap.
    repeat (50) tick(1);
    rate_code_req = 4'h2;
    repeat (150) tick($urandom_range(0, 1));
    // Enable drop with pairs queued, tick while disabled ignored.
    repeat (3) step(0, 1, 1, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    tick(0);
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    tick(0); tick(0);
    // Push coinciding with tick on an empty FIFO in RUN is an underrun.
    tick(1);
    step(0, 1, 1, 0);
    tick(0); tick(0);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) rate_code_req = 4'($urandom);
      step(0, $urandom_range(0, 59) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
